// File: rtl/vga_sync_receiver_pkg.sv
// Shared VGA timing constants and receiver lock-state encoding.
package vga_sync_receiver_pkg;

   localparam int unsigned VgaTotalCols  = 800;
   localparam int unsigned VgaTotalRows  = 525;
   localparam int unsigned VgaActiveCols = 640;
   localparam int unsigned VgaActiveRows = 480;

   localparam int unsigned CountWidth = 10;
   localparam int unsigned ErrWidth   = 8;

   typedef enum logic [1:0] {
      StUnlocked = 2'd0,
      StAligning = 2'd1,
      StLocked   = 2'd2
   } sync_state_e;

endpackage

// File: rtl/vga_sync_receiver_sync_edge_detect.sv
// One-flop capture of a sync input with rising-edge detect against the captured value.
module vga_sync_receiver_sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sync,
   output logic delayed,
   output logic rise
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         delayed <= 1'b0;
      end else begin
         delayed <= sync;
      end
   end

   assign rise = sync & ~delayed;

endmodule

// File: rtl/vga_sync_receiver.sv
// Sync receiver: regenerates column/row counts from generator-style HSync/VSync
// and tracks lock against the configured frame geometry.
module vga_sync_receiver
   import vga_sync_receiver_pkg::*;
#(
   parameter int unsigned TOTAL_COLS  = VgaTotalCols,
   parameter int unsigned TOTAL_ROWS  = VgaTotalRows,
   parameter int unsigned ACTIVE_COLS = VgaActiveCols,
   parameter int unsigned ACTIVE_ROWS = VgaActiveRows,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_HSync,
   input  logic                  i_VSync,
   output logic                  o_HSync,
   output logic                  o_VSync,
   output logic [CountWidth-1:0] o_Col_Count,
   output logic [CountWidth-1:0] o_Row_Count,
   output logic                  o_Active,
   output logic                  o_Frame_Start,
   output logic                  o_Locked,
   output logic                  o_Sync_Error,
   output logic [ErrWidth-1:0]   o_Err_Count
);

   localparam int unsigned GoodWidth = $clog2(LOCK_FRAMES + 1);

   localparam logic [CountWidth-1:0] LastCol    = CountWidth'(TOTAL_COLS - 1);
   localparam logic [CountWidth-1:0] LastRow    = CountWidth'(TOTAL_ROWS - 1);
   localparam logic [CountWidth-1:0] ActiveCols = CountWidth'(ACTIVE_COLS);
   localparam logic [CountWidth-1:0] ActiveRows = CountWidth'(ACTIVE_ROWS);
   localparam logic [GoodWidth-1:0]  LockTarget = GoodWidth'(LOCK_FRAMES);
   localparam logic [ErrWidth-1:0]   ErrMax     = '1;

   logic                  hsync_q;
   logic                  vsync_q;
   logic                  hs_rise;
   logic                  vs_rise;
   logic [CountWidth-1:0] col_q;
   logic [CountWidth-1:0] row_q;
   logic                  at_col_end;
   logic                  at_row_end;
   logic                  line_err;
   logic                  frame_err;
   logic [GoodWidth-1:0]  good_cnt_q;
   logic [GoodWidth-1:0]  good_inc;
   sync_state_e           state_q;
   logic                  locked_q;
   logic                  frame_start_q;
   logic                  sync_err_q;
   logic [ErrWidth-1:0]   err_cnt_q;

   vga_sync_receiver_sync_edge_detect u_hs_edge (
      .clk     (i_Clk),
      .rst     (i_Reset),
      .sync    (i_HSync),
      .delayed (hsync_q),
      .rise    (hs_rise)
   );

   vga_sync_receiver_sync_edge_detect u_vs_edge (
      .clk     (i_Clk),
      .rst     (i_Reset),
      .sync    (i_VSync),
      .delayed (vsync_q),
      .rise    (vs_rise)
   );

   assign at_col_end = (col_q == LastCol);
   assign at_row_end = (row_q == LastRow);

   // Counts free-run in every state; a VSync rise always re-anchors them.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         col_q <= '0;
         row_q <= '0;
      end else if (vs_rise) begin
         col_q <= '0;
         row_q <= '0;
      end else if (at_col_end) begin
         col_q <= '0;
         row_q <= at_row_end ? '0 : row_q + CountWidth'(1);
      end else begin
         col_q <= col_q + CountWidth'(1);
      end
   end

   // Checks use the pre-update counts: edges must land exactly on the wrap points.
   assign line_err  = hs_rise ^ at_col_end;
   assign frame_err = vs_rise ^ (at_col_end & at_row_end);
   assign good_inc  = good_cnt_q + GoodWidth'(1);

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q       <= StUnlocked;
         good_cnt_q    <= '0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         frame_start_q <= vs_rise;
         sync_err_q    <= 1'b0;
         unique case (state_q)
            StUnlocked: begin
               if (vs_rise) begin
                  state_q    <= StAligning;
                  good_cnt_q <= '0;
               end
            end
            StAligning: begin
               if (line_err) begin
                  state_q <= StUnlocked;
               end else if (vs_rise) begin
                  if (frame_err) begin
                     good_cnt_q <= '0;
                  end else if (good_inc == LockTarget) begin
                     state_q    <= StLocked;
                     locked_q   <= 1'b1;
                     good_cnt_q <= '0;
                  end else begin
                     good_cnt_q <= good_inc;
                  end
               end else if (frame_err) begin
                  state_q <= StUnlocked;
               end
            end
            StLocked: begin
               if (line_err || frame_err) begin
                  sync_err_q <= 1'b1;
                  locked_q   <= 1'b0;
                  if (err_cnt_q != ErrMax) begin
                     err_cnt_q <= err_cnt_q + ErrWidth'(1);
                  end
                  // A misplaced VSync edge is still a usable reference: start aligning on it.
                  if (vs_rise) begin
                     state_q    <= StAligning;
                     good_cnt_q <= '0;
                  end else begin
                     state_q <= StUnlocked;
                  end
               end
            end
            default: begin
               state_q  <= StUnlocked;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_HSync       = hsync_q;
   assign o_VSync       = vsync_q;
   assign o_Col_Count   = col_q;
   assign o_Row_Count   = row_q;
   assign o_Active      = locked_q && (col_q < ActiveCols) && (row_q < ActiveRows);
   assign o_Frame_Start = frame_start_q;
   assign o_Locked      = locked_q;
   assign o_Sync_Error  = sync_err_q;
   assign o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 8x5 frame geometry.
module tb_vga_sync_receiver;

   localparam int TC     = 8;
   localparam int TR     = 5;
   localparam int AC     = 5;
   localparam int AR     = 3;
   localparam int LF     = 2;
   localparam int RstCol = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       hsync;
   logic       vsync;
   logic       o_HSync;
   logic       o_VSync;
   logic [9:0] o_Col_Count;
   logic [9:0] o_Row_Count;
   logic       o_Active;
   logic       o_Frame_Start;
   logic       o_Locked;
   logic       o_Sync_Error;
   logic [7:0] o_Err_Count;

   vga_sync_receiver #(
      .TOTAL_COLS  (TC),
      .TOTAL_ROWS  (TR),
      .ACTIVE_COLS (AC),
      .ACTIVE_ROWS (AR),
      .LOCK_FRAMES (LF)
   ) dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_HSync       (hsync),
      .i_VSync       (vsync),
      .o_HSync       (o_HSync),
      .o_VSync       (o_VSync),
      .o_Col_Count   (o_Col_Count),
      .o_Row_Count   (o_Row_Count),
      .o_Active      (o_Active),
      .o_Frame_Start (o_Frame_Start),
      .o_Locked      (o_Locked),
      .o_Sync_Error  (o_Sync_Error),
      .o_Err_Count   (o_Err_Count)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic       exp_q[$];
   logic       exp_lock_cur;
   logic       prev_vs;
   int         act_total;
   int         serr_total;
   logic [9:0] serr_col;
   logic [9:0] serr_row;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {30'd0, o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active, o_Frame_Start,
              o_Locked, o_Sync_Error, o_Err_Count};
   endfunction

   task automatic monitor(input logic hs, input logic vs);
      logic e;
      check("sync_delay", {62'd0, o_HSync, o_VSync}, {62'd0, hs, vs});
      if (o_Active) act_total++;
      if (o_Sync_Error) begin
         serr_total++;
         serr_col = o_Col_Count;
         serr_row = o_Row_Count;
      end
      if (o_Frame_Start) begin
         if (exp_q.size() == 0) begin
            check("frame_start_unexpected", 64'(o_Frame_Start), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("frame_start", {42'd0, o_Col_Count, o_Row_Count, o_VSync, o_Locked},
                  {42'd0, 20'd0, 1'b1, e});
         end
      end
   endtask

   // Drive one input cycle, then sample the registered response on the falling edge.
   task automatic step(input logic hs, input logic vs);
      hsync = hs;
      vsync = vs;
      if (vs && !prev_vs) exp_q.push_back(exp_lock_cur);
      prev_vs = vs;
      @(posedge clk);
      @(negedge clk);
      monitor(hs, vs);
   endtask

   task automatic mid_reset();
      check("locked_before_reset", 64'(o_Locked), 64'd1);
      #1 rst = 1'b1;
      #1 check("reset_outputs_mid", all_outputs(), 64'd0);
      #1 rst = 1'b0;
      prev_vs      = 1'b0;
      exp_lock_cur = 1'b0;
   endtask

   task automatic gen_frame(input int nrows, input int ncols, input int drop_row,
                            input int rst_row, input logic exp_lock);
      exp_lock_cur = exp_lock;
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < ncols; c++) begin
            if (r == rst_row && c == RstCol) mid_reset();
            step((c < AC) && (r != drop_row), r < AR);
         end
      end
      check("frame_start_missing", 64'(exp_q.size()), 64'd0);
   endtask

   int a0;
   int s0;
   int exp_err;

   initial begin
      rst          = 1'b1;
      hsync        = 1'b0;
      vsync        = 1'b0;
      prev_vs      = 1'b0;
      exp_lock_cur = 1'b0;
      act_total    = 0;
      serr_total   = 0;
      serr_col     = '0;
      serr_row     = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs_init", all_outputs(), 64'd0);
      rst = 1'b0;

      // Short lines never lock and never flag errors.
      s0 = serr_total;
      repeat (3) gen_frame(TR, TC - 1, -1, -1, 1'b0);
      check("short_line_no_error", 64'(serr_total - s0), 64'd0);
      check("short_line_unlocked", 64'(o_Locked), 64'd0);

      // Clean frames: lock on the third VSync rise.
      s0 = serr_total;
      a0 = act_total;
      gen_frame(TR, TC, -1, -1, 1'b0);
      check("active_unlocked", 64'(act_total - a0), 64'd0);
      gen_frame(TR, TC, -1, -1, 1'b0);
      a0 = act_total;
      gen_frame(TR, TC, -1, -1, 1'b1);
      check("active_lock_frame", 64'(act_total - a0), 64'(AC * AR));
      a0 = act_total;
      gen_frame(TR, TC, -1, -1, 1'b1);
      check("active_locked", 64'(act_total - a0), 64'(AC * AR));
      check("clean_err_count", 64'(o_Err_Count), 64'd0);
      check("clean_no_error", 64'(serr_total - s0), 64'd0);

      // Missing HSync edge on row 2.
      s0 = serr_total;
      gen_frame(TR, TC, 2, -1, 1'b1);
      check("hs_drop_pulses", 64'(serr_total - s0), 64'd1);
      check("hs_drop_pos", {44'd0, serr_col, serr_row}, {44'd0, 10'd0, 10'd2});
      check("hs_drop_unlocked", 64'(o_Locked), 64'd0);
      check("hs_drop_err_count", 64'(o_Err_Count), 64'd1);
      gen_frame(TR, TC, -1, -1, 1'b0);
      gen_frame(TR, TC, -1, -1, 1'b0);
      gen_frame(TR, TC, -1, -1, 1'b1);

      // VSync one line early: error, realign on that edge, lock after two clean frames.
      s0 = serr_total;
      gen_frame(TR - 1, TC, -1, -1, 1'b1);
      gen_frame(TR, TC, -1, -1, 1'b0);
      check("vs_early_pulses", 64'(serr_total - s0), 64'd1);
      check("vs_early_pos", {44'd0, serr_col, serr_row}, 64'd0);
      check("vs_early_err_count", 64'(o_Err_Count), 64'd2);
      gen_frame(TR, TC, -1, -1, 1'b0);
      gen_frame(TR, TC, -1, -1, 1'b1);
      check("vs_early_relocked", 64'(o_Locked), 64'd1);

      // Repeated errors saturate the error counter.
      exp_err = 2;
      s0      = serr_total;
      for (int i = 0; i < 260; i++) begin
         gen_frame(TR - 1, TC, -1, -1, 1'b1);
         gen_frame(TR, TC, -1, -1, 1'b0);
         gen_frame(TR, TC, -1, -1, 1'b0);
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
         check("err_count_sat", 64'(o_Err_Count), 64'(exp_err));
      end
      check("sat_pulses", 64'(serr_total - s0), 64'd260);

      // Reset mid-frame while locked, then the normal lock sequence.
      check("pre_reset_err_count", 64'(o_Err_Count), 64'd255);
      gen_frame(TR, TC, -1, 2, 1'b1);
      check("post_reset_err_count", 64'(o_Err_Count), 64'd0);
      gen_frame(TR, TC, -1, -1, 1'b0);
      gen_frame(TR, TC, -1, -1, 1'b0);
      gen_frame(TR, TC, -1, -1, 1'b1);
      a0 = act_total;
      s0 = serr_total;
      gen_frame(TR, TC, -1, -1, 1'b1);
      check("post_reset_active", 64'(act_total - a0), 64'(AC * AR));
      check("post_reset_no_error", 64'(serr_total - s0), 64'd0);
      check("post_reset_locked", 64'(o_Locked), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
